// File: rtl/delay_us_pkg.sv
// Shared definitions for the multi-channel microsecond delay timer.
package delay_us_pkg;

  localparam int   DEFAULT_WIDTH = 16;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RUNNING = 1'b1
  } ch_state_e;

endpackage

// File: rtl/delay_us_channel.sv
// One timer channel: step edge detect, IDLE/RUNNING FSM, down-counter, done/busy.
// Optional feature macro: DELAY_US_REMAIN_EN exposes the live count on 'remaining'.
module delay_us_channel
  import delay_us_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  // Set when ticks are prescaled: the first tick after a start only ends the
  // partial prescaler period, so the full D*TICK_DIV minimum is guaranteed.
  parameter bit PARTIAL_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             step,
  input  logic             abort,
  input  logic             mode,
  input  logic [WIDTH-1:0] delay,
  output logic             done,
  output logic             busy
`ifdef DELAY_US_REMAIN_EN
  ,
  output logic [WIDTH-1:0] remaining
`endif
);

  ch_state_e        state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] dly_q, dly_n;
  logic             mode_q, mode_n;
  logic             partial, partial_n;
  logic             step_q;

  logic             start;
  logic             expire;
  logic [WIDTH-1:0] eff;

  assign start  = step & ~step_q;
  // A zero delay behaves as one tick.
  assign eff    = (delay == '0) ? WIDTH'(1) : delay;
  assign expire = (state == ST_RUNNING) && tick && !partial && (cnt == WIDTH'(1));

  // done is combinational so it lands in the last busy cycle and can be
  // vetoed by an abort (or reset) presented in that same cycle.
  assign done = expire & ~abort & ~rst;
  assign busy = (state == ST_RUNNING);

`ifdef DELAY_US_REMAIN_EN
  // cnt is cleared whenever the channel drops to IDLE, so it reads 0 there.
  assign remaining = cnt;
`endif

  // State, counter, latched config and step history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      dly_q   <= '0;
      mode_q  <= MODE_ONESHOT;
      partial <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      dly_q   <= dly_n;
      mode_q  <= mode_n;
      partial <= partial_n;
      step_q  <= step;
    end
  end

  // Next-state logic: abort beats start, start (retrigger) beats counting.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    dly_n     = dly_q;
    mode_n    = mode_q;
    partial_n = partial;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_n   = ST_RUNNING;
          cnt_n     = eff;
          dly_n     = eff;
          mode_n    = mode;
          partial_n = PARTIAL_EN;
        end
      end
      ST_RUNNING: begin
        if (abort) begin
          state_n   = ST_IDLE;
          cnt_n     = '0;
          partial_n = 1'b0;
        end else if (start) begin
          cnt_n     = eff;
          dly_n     = eff;
          mode_n    = mode;
          partial_n = PARTIAL_EN;
        end else if (tick) begin
          if (partial) begin
            partial_n = 1'b0;
          end else if (cnt == WIDTH'(1)) begin
            if (mode_q == MODE_PERIODIC) begin
              cnt_n = dly_q;
            end else begin
              state_n = ST_IDLE;
              cnt_n   = '0;
            end
          end else begin
            cnt_n = cnt - WIDTH'(1);
          end
        end
      end
      default: begin
        state_n   = ST_IDLE;
        cnt_n     = '0;
        partial_n = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/delay_us_multi.sv
// Multi-channel microsecond delay timer: shared tick prescaler plus CH channels.
// Optional feature macro: DELAY_US_REMAIN_EN adds the 'remaining' live-count port.
module delay_us_multi
  import delay_us_pkg::*;
#(
  parameter int CH       = 4,
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int TICK_DIV = 1
) (
  input  logic                clk_1MHz,
  input  logic                rst,
  input  logic [CH-1:0]       step,
  input  logic [CH-1:0]       abort,
  input  logic [CH-1:0]       mode,
  input  logic [CH*WIDTH-1:0] delay_us,
  output logic [CH-1:0]       done,
  output logic [CH-1:0]       busy
`ifdef DELAY_US_REMAIN_EN
  ,
  output logic [CH*WIDTH-1:0] remaining
`endif
);

  logic tick;

  if (TICK_DIV <= 1) begin : g_no_pre
    assign tick = 1'b1;
  end else begin : g_pre
    localparam int PW = $clog2(TICK_DIV);
    logic [PW-1:0] pre;

    // Free-running prescaler; starts never touch it so channels share phase.
    always_ff @(posedge clk_1MHz) begin
      if (rst)                          pre <= '0;
      else if (pre == PW'(TICK_DIV-1))  pre <= '0;
      else                              pre <= pre + PW'(1);
    end

    assign tick = (pre == PW'(TICK_DIV-1));
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    delay_us_channel #(
      .WIDTH      (WIDTH),
      .PARTIAL_EN (TICK_DIV > 1)
    ) u_ch (
      .clk       (clk_1MHz),
      .rst       (rst),
      .tick      (tick),
      .step      (step[i]),
      .abort     (abort[i]),
      .mode      (mode[i]),
      .delay     (delay_us[i*WIDTH +: WIDTH]),
      .done      (done[i]),
      .busy      (busy[i])
`ifdef DELAY_US_REMAIN_EN
      ,
      .remaining (remaining[i*WIDTH +: WIDTH])
`endif
    );
  end

endmodule

// File: tb/tb_delay_us_multi.sv
// Scoreboard bench for delay_us_multi: stimulus pushes expected done cycles,
// a negedge monitor pops and compares whenever done pulses.
module tb_delay_us_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  step0, abort0, mode0, done0, busy0;
  logic [63:0] dly0;
  logic [3:0]  step1, abort1, mode1, done1, busy1;
  logic [63:0] dly1;
`ifdef DELAY_US_REMAIN_EN
  logic [63:0] rem0, rem1;
`endif

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  int exp_q[4][$];
  int win_lo[$];
  int win_hi[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  delay_us_multi #(.CH(4), .WIDTH(16), .TICK_DIV(1)) u0 (
    .clk_1MHz (clk), .rst (rst), .step (step0), .abort (abort0), .mode (mode0),
    .delay_us (dly0), .done (done0), .busy (busy0)
`ifdef DELAY_US_REMAIN_EN
    , .remaining (rem0)
`endif
  );

  delay_us_multi #(.CH(4), .WIDTH(16), .TICK_DIV(10)) u1 (
    .clk_1MHz (clk), .rst (rst), .step (step1), .abort (abort1), .mode (mode1),
    .delay_us (dly1), .done (done1), .busy (busy1)
`ifdef DELAY_US_REMAIN_EN
    , .remaining (rem1)
`endif
  );

  function automatic void chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: every done pulse must match the head of its channel queue.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      while (exp_q[i].size() > 0 && exp_q[i][0] < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL done_missed ch%0d: got no pulse, expected at cycle %0d", i, exp_q[i][0]);
        void'(exp_q[i].pop_front());
      end
      if (done0[i]) begin
        if (exp_q[i].size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL done_unexpected ch%0d: got pulse at cycle %0d, expected none", i, cyc);
        end else begin
          chk($sformatf("done_cycle_ch%0d", i), cyc, exp_q[i].pop_front());
        end
      end
    end
    while (win_hi.size() > 0 && win_hi[0] < cyc) begin
      n_chk++; n_fail++;
      $display("FAIL div_done_missed: got no pulse, required by cycle %0d", win_hi[0]);
      void'(win_lo.pop_front()); void'(win_hi.pop_front());
    end
    if (done1[0]) begin
      if (win_lo.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL div_done_unexpected: got pulse at cycle %0d, expected none", cyc);
      end else begin
        int lo, hi;
        lo = win_lo.pop_front(); hi = win_hi.pop_front();
        n_chk++;
        if (cyc < lo || cyc > hi) begin
          n_fail++;
          $display("FAIL div_done_window: got cycle %0d, required %0d..%0d", cyc, lo, hi);
        end
      end
    end
    if (done1[3:1] != 3'b000) begin
      n_chk++; n_fail++;
      $display("FAIL div_done_idle_ch: got %b, expected 000", done1[3:1]);
    end
  end

  task automatic go_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic start0(input int ch, input logic [15:0] d, input logic m);
    dly0[ch*16 +: 16] = d;
    mode0[ch] = m;
    step0[ch] = 1'b1;
  endtask

  task automatic chk_rem0(input string nm, input int ch, input int exp);
`ifdef DELAY_US_REMAIN_EN
    chk(nm, rem0[ch*16 +: 16], exp);
`else
    if (ch < 0 || exp < 0) $display("%s", nm);
`endif
  endtask

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: got cycle %0d, expected completion earlier", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n3, s, t;
    rst = 1'b1;
    step0 = '0; abort0 = '0; mode0 = '0; dly0 = '0;
    step1 = '0; abort1 = '0; mode1 = '0; dly1 = '0;
    repeat (3) @(posedge clk);
    #2;
    @(negedge clk);
    chk("reset_done0", done0, 0);
    chk("reset_busy0", busy0, 0);
    chk("reset_busy1", busy1, 0);
    chk_rem0("reset_rem0", 0, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    go_cyc(cyc + 2);

    // ch3: maximum delay, runs in the background
    n3 = cyc;
    start0(3, 16'hFFFF, 1'b0);
    exp_q[3].push_back(n3 + 65535);
    go_cyc(n3 + 1); step0[3] = 1'b0;

    // ch0 one-shot 1000, step held 30 cycles
    go_cyc(cyc + 1);
    n = cyc;
    start0(0, 16'd1000, 1'b0);
    exp_q[0].push_back(n + 1000);
    @(negedge clk); chk("t1_busy_before", busy0[0], 0);
    go_cyc(n + 1); @(negedge clk);
    chk("t1_busy_first", busy0[0], 1);
    chk_rem0("t1_rem_first", 0, 1000);
    go_cyc(n + 30); step0[0] = 1'b0;
    go_cyc(n + 1000); @(negedge clk);
    chk("t1_busy_last", busy0[0], 1);
    chk_rem0("t1_rem_last", 0, 1);
    go_cyc(n + 1001); @(negedge clk);
    chk("t1_busy_after", busy0[0], 0);
    chk_rem0("t1_rem_idle", 0, 0);

    // ch2 delay 0 behaves as 1
    go_cyc(cyc + 2);
    n = cyc;
    start0(2, 16'd0, 1'b0);
    exp_q[2].push_back(n + 1);
    go_cyc(n + 1); step0[2] = 1'b0;
    @(negedge clk); chk("t3_busy_d0", busy0[2], 1);
    go_cyc(n + 2); @(negedge clk); chk("t3_idle_d0", busy0[2], 0);

    // ch1 periodic 5, ten pulses then abort
    go_cyc(cyc + 2);
    n = cyc;
    start0(1, 16'd5, 1'b1);
    for (int k = 1; k <= 10; k++) exp_q[1].push_back(n + 5 * k);
    go_cyc(n + 1); step0[1] = 1'b0;
    go_cyc(n + 52); abort0[1] = 1'b1;
    go_cyc(n + 53); abort0[1] = 1'b0;
    @(negedge clk); chk("t2_busy_abort", busy0[1], 0);
    go_cyc(n + 80); @(negedge clk); chk("t2_busy_stay", busy0[1], 0);

    // ch0 retrigger: 100 then 20 at cycle 50
    go_cyc(cyc + 2);
    n = cyc;
    start0(0, 16'd100, 1'b0);
    exp_q[0].push_back(n + 70);
    go_cyc(n + 1); step0[0] = 1'b0;
    go_cyc(n + 50); start0(0, 16'd20, 1'b0);
    go_cyc(n + 51); step0[0] = 1'b0;
    go_cyc(n + 70); @(negedge clk); chk("t4_busy_last", busy0[0], 1);
    go_cyc(n + 71); @(negedge clk); chk("t4_busy_after", busy0[0], 0);

    // ch0 abort and step together: abort wins
    go_cyc(cyc + 2);
    n = cyc;
    start0(0, 16'd5, 1'b0); abort0[0] = 1'b1;
    go_cyc(n + 1); step0[0] = 1'b0; abort0[0] = 1'b0;
    @(negedge clk); chk("t4_abort_step_busy", busy0[0], 0);
    go_cyc(n + 10); @(negedge clk); chk("t4_abort_step_stay", busy0[0], 0);

    // ch1 expiry and start in the same cycle
    go_cyc(cyc + 2);
    n = cyc;
    start0(1, 16'd4, 1'b0);
    exp_q[1].push_back(n + 4);
    go_cyc(n + 1); step0[1] = 1'b0;
    go_cyc(n + 4); start0(1, 16'd6, 1'b0);
    exp_q[1].push_back(n + 10);
    go_cyc(n + 5); step0[1] = 1'b0;
    @(negedge clk); chk("exp_start_busy", busy0[1], 1);
    go_cyc(n + 11); @(negedge clk); chk("exp_start_idle", busy0[1], 0);

    // ch2 abort on the expiry cycle: no done
    go_cyc(cyc + 2);
    n = cyc;
    start0(2, 16'd3, 1'b0);
    go_cyc(n + 1); step0[2] = 1'b0;
    go_cyc(n + 3); abort0[2] = 1'b1;
    go_cyc(n + 4); abort0[2] = 1'b0;
    @(negedge clk); chk("abort_exp_busy", busy0[2], 0);

    // ch3 end of the 65535-tick run
    go_cyc(n3 + 65535); @(negedge clk); chk("t3_max_busy_last", busy0[3], 1);
    go_cyc(n3 + 65536); @(negedge clk); chk("t3_max_idle", busy0[3], 0);

    // all four channels together
    go_cyc(cyc + 2);
    n = cyc;
    start0(0, 16'd3, 1'b0); start0(1, 16'd7, 1'b0);
    start0(2, 16'd11, 1'b0); start0(3, 16'd13, 1'b0);
    exp_q[0].push_back(n + 3);  exp_q[1].push_back(n + 7);
    exp_q[2].push_back(n + 11); exp_q[3].push_back(n + 13);
    go_cyc(n + 1); step0 = '0;
    @(negedge clk); chk("t5_busy_all", busy0, 4'hF);
    go_cyc(n + 14); @(negedge clk); chk("t5_idle_all", busy0, 0);

    // reset mid-run
    go_cyc(cyc + 2);
    s = cyc;
    for (int i = 0; i < 4; i++) start0(i, 16'd20, 1'b1);
    go_cyc(s + 1); step0 = '0;
    go_cyc(s + 10); rst = 1'b1;
    go_cyc(s + 11); rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_busy", busy0, 0);
    chk("t5_rst_done", done0, 0);
    chk_rem0("t5_rst_rem", 2, 0);
    go_cyc(s + 50); @(negedge clk); chk("t5_rst_stay", busy0, 0);

    // prescaled instance: delay 5, TICK_DIV 10
    go_cyc(cyc + 3);
    t = cyc;
    dly1[15:0] = 16'd5; mode1[0] = 1'b0; step1[0] = 1'b1;
    win_lo.push_back(t + 51); win_hi.push_back(t + 61);
    go_cyc(t + 1); step1[0] = 1'b0;
    @(negedge clk); chk("t6_busy", busy1[0], 1);
`ifdef DELAY_US_REMAIN_EN
    chk("t6_rem_first", rem1[15:0], 5);
`endif
    go_cyc(t + 70); @(negedge clk); chk("t6_idle", busy1[0], 0);
`ifdef DELAY_US_REMAIN_EN
    chk("t6_rem_idle", rem1[15:0], 0);
`endif

    go_cyc(cyc + 5);
    for (int i = 0; i < 4; i++) chk($sformatf("queue_empty_ch%0d", i), exp_q[i].size(), 0);
    chk("queue_empty_div", win_lo.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
